ram_access_ctrl: RTL

Port controller that drives the single-port block RAM (`clock`, `clken`, `wren`, `address`, `data`, `q`; registered read, one-cycle latency) on behalf of two clients: the ROM/RAM download stream and a CPU-side request/acknowledge bus. After reset it sweeps the whole RAM to a fixed clear value. It then arbitrates between download writes, which have priority, and CPU reads and writes. It sits between the RAM instance and the CPU/download glue in each memory region of the core.

---
 rtl/ram_access_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// Single-port block RAM front end shared by the download stream and a CPU
// request/acknowledge client. An optional clear sweep runs after reset.
module ram_access_ctrl #(
  parameter int                      addr_width_g   = 11,
  parameter int                      data_width_g   = 8,
  parameter bit                      clear_enable_g = 1'b1,
  parameter logic [data_width_g-1:0] clear_value_g  = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    dl_active,
  input  logic                    dl_wr,
  input  logic [addr_width_g-1:0] dl_addr,
  input  logic [data_width_g-1:0] dl_data,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [addr_width_g-1:0] cpu_addr,
  input  logic [data_width_g-1:0] cpu_wdata,
  output logic                    cpu_ack,
  output logic [data_width_g-1:0] cpu_rdata,
  output logic                    ram_clken,
  output logic                    ram_wren,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  input  logic [data_width_g-1:0] ram_q,
  output logic                    busy,
  output logic                    dl_overrun
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_DL,
    S_CPU_RD1,
    S_CPU_RD2,
    S_CPU_ACK
  } state_e;

  state_e                  state_q, state_d;
  logic [addr_width_g:0]   clr_cnt_q, clr_cnt_d;
  logic                    ram_clken_q, ram_clken_d;
  logic                    ram_wren_q, ram_wren_d;
  logic [addr_width_g-1:0] ram_address_q, ram_address_d;
  logic [data_width_g-1:0] ram_data_q, ram_data_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic [data_width_g-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                    busy_q, busy_d;
  logic                    dl_overrun_q, dl_overrun_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [addr_width_g-1:0] hold_addr_q, hold_addr_d;
  logic [data_width_g-1:0] hold_data_q, hold_data_d;

  logic dispatch;
  logic drain;
  logic direct;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    ram_clken_d   = 1'b0;
    ram_wren_d    = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    cpu_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    dl_overrun_d  = dl_overrun_q;
    hold_valid_d  = hold_valid_q;
    hold_addr_d   = hold_addr_q;
    hold_data_d   = hold_data_q;
    dispatch      = 1'b0;
    drain         = 1'b0;
    direct        = 1'b0;

    case (state_q)
      S_CLEAR: begin
        // The extra counter bit marks completion, so the sweep never wraps.
        if (!clr_cnt_q[addr_width_g]) begin
          ram_clken_d   = 1'b1;
          ram_wren_d    = 1'b1;
          ram_address_d = clr_cnt_q[addr_width_g-1:0];
          ram_data_d    = clear_value_g;
          clr_cnt_d     = clr_cnt_q + (addr_width_g+1)'(1);
        end else begin
          dispatch = 1'b1;
        end
      end
      S_IDLE, S_CPU_ACK: dispatch = 1'b1;
      S_DL: begin
        if (hold_valid_q) drain = 1'b1;
        else if (dl_wr)   direct = 1'b1;
      end
      S_CPU_RD1: state_d = S_CPU_RD2;
      S_CPU_RD2: begin
        state_d     = S_CPU_ACK;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = ram_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Arbitration point: download traffic first, then the CPU.
    if (dispatch) begin
      state_d = S_IDLE;
      if (hold_valid_q) begin
        drain = 1'b1;
        if (dl_active) state_d = S_DL;
      end else if (dl_wr && state_q == S_IDLE) begin
        direct = 1'b1;
        if (dl_active) state_d = S_DL;
      end else if (dl_active) begin
        state_d = S_DL;
      end else if (cpu_req) begin
        ram_clken_d   = 1'b1;
        ram_wren_d    = cpu_we;
        ram_address_d = cpu_addr;
        if (cpu_we) begin
          ram_data_d = cpu_wdata;
          cpu_ack_d  = 1'b1;
        end else begin
          state_d = S_CPU_RD1;
        end
      end
    end

    if (drain) begin
      ram_clken_d   = 1'b1;
      ram_wren_d    = 1'b1;
      ram_address_d = hold_addr_q;
      ram_data_d    = hold_data_q;
    end else if (direct) begin
      ram_clken_d   = 1'b1;
      ram_wren_d    = 1'b1;
      ram_address_d = dl_addr;
      ram_data_d    = dl_data;
    end

    // A strobe not written this cycle is parked; a slot emptied this cycle
    // can take it, otherwise the strobe is lost and flagged.
    if (dl_wr && !direct) begin
      if (!hold_valid_q || drain) begin
        hold_valid_d = 1'b1;
        hold_addr_d  = dl_addr;
        hold_data_d  = dl_data;
      end else begin
        dl_overrun_d = 1'b1;
      end
    end else if (drain) begin
      hold_valid_d = 1'b0;
    end

    if (state_q == S_DL && !dl_active && !hold_valid_d) state_d = S_IDLE;

    busy_d = (state_d == S_CLEAR) || (state_d == S_DL);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if (clear_enable_g) state_q <= S_CLEAR;
      else                state_q <= S_IDLE;
      clr_cnt_q     <= '0;
      ram_clken_q   <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      busy_q        <= clear_enable_g;
      dl_overrun_q  <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      ram_clken_q   <= ram_clken_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      busy_q        <= busy_d;
      dl_overrun_q  <= dl_overrun_d;
      hold_valid_q  <= hold_valid_d;
      hold_addr_q   <= hold_addr_d;
      hold_data_q   <= hold_data_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ram_clken   = ram_clken_q;
  assign ram_wren    = ram_wren_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign busy        = busy_q;
  assign dl_overrun  = dl_overrun_q;

endmodule
